instr_fetch_buffer: RTL
=======================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have ports clk in 1 (clock, all state on rising edge) and reset in 1 (reset: synchronous, active-high).
REQ-002 SHALL have ports go in 1 (fetch enable) and pc_in in 32 (current fetch PC from the PC register).
REQ-003 SHALL have port flush in 1 (branch taken this cycle; discard all in-flight and buffered fetches).
REQ-004 SHALL have ports imem_req out 1 (fetch request) and imem_addr out 32 (request address, equal to pc_in).
REQ-005 SHALL have ports imem_rvalid in 1 (response valid) and imem_rdata in 32 (response word).
REQ-006 SHALL have ports id_valid out 1, id_instr out 32, id_pc out 32 (decode-side entry) and id_ready in 1 (decode accepts).
REQ-007 SHALL have port fetch_stall out 1 (hold request to the PC register, driven into its stall bit 2).

Function
REQ-008 SHALL hold a 4-entry in-order FIFO of {pc, instr} pairs plus a 2-entry pending-PC queue for outstanding requests.
REQ-009 SHALL assert imem_req combinationally when go=1, reset=0, flush=0, outstanding<2, and fifo_count+outstanding<4.
REQ-010 SHALL drive imem_addr=pc_in at all times; a request is issued in any cycle where imem_req=1 (memory always accepts).
REQ-011 SHALL push pc_in into the pending-PC queue on each issued request.
REQ-012 SHALL drive fetch_stall = go & ~imem_req & ~flush, so the PC holds exactly when no request is issued; fetch_stall=0 when go=0.
REQ-013 SHALL accept responses in order, latency >=1 cycle, at most one per cycle; each response pops the pending-PC queue and writes {pc, imem_rdata} into the FIFO.
REQ-014 SHALL present the FIFO head on id_valid/id_pc/id_instr; an entry is consumed on the edge where id_valid=1 and id_ready=1.
REQ-015 SHALL allow push and pop in the same cycle, leaving fifo_count unchanged.
REQ-016 SHALL support issue and response in the same cycle, leaving outstanding unchanged.
REQ-017 SHALL, on flush=1, empty the FIFO on that edge, set a drop counter to the outstanding count after that edge, and clear the pending-PC queue.
REQ-018 SHALL discard any response arriving while the drop counter is non-zero, decrementing the counter; a response arriving in the flush cycle itself SHALL also be discarded.
REQ-019 SHALL not issue a request in the flush cycle; issue resumes the next cycle at the redirected pc_in.
REQ-020 SHALL deassert id_valid in the cycle after flush; an id handshake coincident with flush is ignored.
REQ-021 SHALL never overflow the FIFO; REQ-009 guarantees that every response has a free slot.
REQ-022 SHALL keep buffered entries and continue accepting responses when go=0; only issue stops.

Reset
REQ-023 SHALL, while reset=1, clear the FIFO, the pending-PC queue, the outstanding count and the drop counter.
REQ-024 SHALL hold imem_req=0, fetch_stall=0 and id_valid=0 during reset; id_pc and id_instr SHALL read 0.
REQ-025 SHALL treat reset mid-operation as a full abort; responses to pre-reset requests arriving after reset are not supported.

Configuration
REQ-026 SHALL, when macro IFB_BYPASS_EN is defined, present a response directly on id_valid/id_pc/id_instr in the same cycle as imem_rvalid if the FIFO is empty and the response is not dropped; if id_ready=1, the entry is not written to the FIFO.
REQ-027 SHALL, without IFB_BYPASS_EN, make a response visible on id_valid exactly one cycle after imem_rvalid.

Verification
REQ-028 SHALL cover streaming: go=1, pc_in 0,4,8, 1-cycle memory, id_ready=1 -> id_pc 0,4,8 on consecutive cycles, fetch_stall=0 throughout.
REQ-029 SHALL cover back-pressure: id_ready=0 with 1-cycle memory -> 4 entries buffered, imem_req=0 and fetch_stall=1 from the cycle fifo_count+outstanding reaches 4.
REQ-030 SHALL cover flush: 2 requests outstanding (pc 0x10, 0x14), flush=1 with pc_in redirect 0x100 -> both responses dropped, next id_pc=0x100.
REQ-031 SHALL cover the simultaneous case: imem_rvalid=1 and flush=1 in the same cycle -> response dropped, id_valid=0 next cycle.
REQ-032 SHALL cover latency: 3-cycle memory -> outstanding capped at 2, fetch_stall=1 while both slots are busy, in-order id_pc.
REQ-033 SHALL cover reset mid-stream with 3 entries buffered -> id_valid=0 and imem_req=0 on the cycle after reset.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues up to two in-flight imem requests, tracks their PCs and
// queues {pc, instr} pairs for decode. Define IFB_BYPASS_EN to forward a response straight to decode.
module instr_fetch_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        fetch_stall
);

  logic [31:0] r_fifo_pc    [4];
  logic [31:0] r_fifo_instr [4];
  logic [1:0]  r_fifo_rd;
  logic [1:0]  r_fifo_wr;
  logic [2:0]  r_fifo_count;

  logic [31:0] r_pend_pc [2];
  logic        r_pend_rd;
  logic        r_pend_wr;

  // r_outstanding counts every request still in memory, including ones marked for dropping.
  logic [1:0]  r_outstanding;
  logic [1:0]  r_drop_cnt;

  logic        w_fifo_empty;
  logic        w_room;
  logic        w_resp_keep;
  logic [31:0] w_resp_pc;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head_pc;
  logic [31:0] w_head_instr;

  assign w_fifo_empty = (r_fifo_count == 3'd0);
  assign w_room       = ({1'b0, r_fifo_count} + {2'b00, r_outstanding}) < 4'd4;

  assign imem_req    = go & ~reset & ~flush & (r_outstanding < 2'd2) & w_room;
  assign imem_addr   = pc_in;
  assign fetch_stall = go & ~reset & ~imem_req & ~flush;

  assign w_resp_keep = imem_rvalid & ~reset & ~flush & (r_drop_cnt == 2'd0);
  assign w_resp_pc   = r_pend_pc[r_pend_rd];

`ifdef IFB_BYPASS_EN
  assign w_bypass = w_resp_keep & w_fifo_empty;
  assign id_valid = ~reset & (~w_fifo_empty | w_bypass);
  assign w_push   = w_resp_keep & ~(w_bypass & id_ready);
`else
  assign w_bypass = 1'b0;
  assign id_valid = ~reset & ~w_fifo_empty;
  assign w_push   = w_resp_keep;
`endif

  assign w_pop = ~w_fifo_empty & id_ready & ~flush;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_head_pc    = r_fifo_pc[r_fifo_rd];
    w_head_instr = r_fifo_instr[r_fifo_rd];
    if (w_bypass) begin
      w_head_pc    = w_resp_pc;
      w_head_instr = imem_rdata;
    end
  end

  assign id_pc    = id_valid ? w_head_pc    : 32'h0;
  assign id_instr = id_valid ? w_head_instr : 32'h0;

  // NOTE: storage arrays carry no reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_fifo_wr]    <= w_resp_pc;
      r_fifo_instr[r_fifo_wr] <= imem_rdata;
    end
    if (imem_req) begin
      r_pend_pc[r_pend_wr] <= pc_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_rd     <= 2'd0;
      r_fifo_wr     <= 2'd0;
      r_fifo_count  <= 3'd0;
      r_pend_rd     <= 1'b0;
      r_pend_wr     <= 1'b0;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
    end else if (flush) begin
      // Nothing issues in a flush cycle; a response landing now is itself discarded.
      r_fifo_rd     <= 2'd0;
      r_fifo_wr     <= 2'd0;
      r_fifo_count  <= 3'd0;
      r_pend_rd     <= 1'b0;
      r_pend_wr     <= 1'b0;
      r_outstanding <= r_outstanding - 2'(imem_rvalid);
      r_drop_cnt    <= r_outstanding - 2'(imem_rvalid);
    end else begin
      if (w_push) r_fifo_wr <= r_fifo_wr + 2'd1;
      if (w_pop)  r_fifo_rd <= r_fifo_rd + 2'd1;
      r_fifo_count <= r_fifo_count + 3'(w_push) - 3'(w_pop);

      if (imem_req) r_pend_wr <= ~r_pend_wr;
      if (imem_rvalid) begin
        if (r_drop_cnt != 2'd0) r_drop_cnt <= r_drop_cnt - 2'd1;
        else                    r_pend_rd  <= ~r_pend_rd;
      end
      r_outstanding <= r_outstanding + 2'(imem_req) - 2'(imem_rvalid);
    end
  end

endmodule
